// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants for the KGP-RISC datapath, regfile_sb and its bench.
// Pure definitions: no logic, no latency, no flow control.
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int ZERO_IDX   = 0;
  localparam int TAP_IDX    = 12;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file access bundle: read ports, writeback, issue reservation and debug outputs.
// Master is the datapath; slave is regfile_sb. No handshake, every strobe is accepted.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DATA_W-1:0]        tap_out;
  logic                     wr_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, tap_out, wr_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, tap_out, wr_err
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus sticky unreserved-write error.
// Updates one cycle after the strobes; never stalls the issue or writeback stages.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic [ADDR_W-1:0]      wrAddr,
  input  logic                   rsvEn,
  input  logic [ADDR_W-1:0]      rsvAddr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   wrErr
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [(1<<ADDR_W)-1:0] busyQ;
  logic                   wrErrQ;
  logic                   wrCounts;
  logic                   rsvCounts;

  assign wrCounts  = wrEn  && !(ZERO_REG != 0 && wrAddr  == ZERO_A);
  assign rsvCounts = rsvEn && !(ZERO_REG != 0 && rsvAddr == ZERO_A);

  // The reservation is applied after the clear so a same-address pair leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyQ  <= '0;
      wrErrQ <= 1'b0;
    end else begin
      if (wrCounts) begin
        busyQ[wrAddr] <= 1'b0;
        if (!busyQ[wrAddr]) begin
          wrErrQ <= 1'b1;
        end
      end
      if (rsvCounts) begin
        busyQ[rsvAddr] <= 1'b1;
      end
    end
  end

  assign busy  = busyQ;
  assign wrErr = wrErrQ;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass, pending-write scoreboard and registered tap.
// Reads are zero-latency, tap_out lags a write by one cycle; no backpressure on any port.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TAP_REG  = TAP_IDX
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] TAP_A  = ADDR_W'(TAP_REG);

  if (NUM_RD < 1 || NUM_RD > 4) begin : gBadNumRd
    $error("regfile_sb: NUM_RD must be 1..4");
  end
  if (TAP_REG < 0 || TAP_REG >= DEPTH) begin : gBadTapReg
    $error("regfile_sb: TAP_REG outside the register file");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] tapQ;
  logic [DEPTH-1:0]  busyVec;
  logic              wrKeep;

  assign wrKeep = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == ZERO_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrKeep) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Tap sees the value the register holds after this edge, including the write landing now.
  always_ff @(posedge clk) begin
    if (rst) begin
      tapQ <= '0;
    end else if (wrKeep && bus.wr_addr == TAP_A) begin
      tapQ <= bus.wr_data;
    end else begin
      tapQ <= regs[TAP_A];
    end
  end

  assign bus.tap_out = tapQ;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .wrEn    (bus.wr_en),
    .wrAddr  (bus.wr_addr),
    .rsvEn   (bus.rsv_en),
    .rsvAddr (bus.rsv_addr),
    .busy    (busyVec),
    .wrErr   (bus.wr_err)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic              isZero;
    logic              wrHit;
    logic              rsvHit;

    assign addr   = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign isZero = (ZERO_REG != 0) && (addr == ZERO_A);
    assign wrHit  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr);
    assign rsvHit = bus.rsv_en && (bus.rsv_addr == addr);

    assign bus.rd_data[p*DATA_W +: DATA_W] = isZero ? '0 :
                                             wrHit  ? bus.wr_data : regs[addr];
    // A write retiring this cycle hides the busy bit unless it is being re-reserved.
    assign bus.rd_busy[p] = !isZero && !(wrHit && !rsvHit) && busyVec[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an array model, on a bypassing and a non-bypassing instance.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifA ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifB ();

  assign ifB.rd_addr  = ifA.rd_addr;
  assign ifB.wr_en    = ifA.wr_en;
  assign ifB.wr_addr  = ifA.wr_addr;
  assign ifB.wr_data  = ifA.wr_data;
  assign ifB.rsv_en   = ifA.rsv_en;
  assign ifB.rsv_addr = ifA.rsv_addr;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1), .TAP_REG(TAP_IDX))
    dutA (.clk(clk), .rst(rst), .bus(ifA));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0), .TAP_REG(TAP_IDX))
    dutB (.clk(clk), .rst(rst), .bus(ifB));

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  // Reference state: what each register holds, whether a write is pending, the error flag and tap.
  logic [DW-1:0] mReg [32];
  bit            mBusy [32];
  bit            mErr;
  logic [DW-1:0] mTap;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rdA(input int p);
    logic [NR*AW-1:0] v;
    v = ifA.rd_addr;
    return v[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] expData(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && ifA.wr_en && int'(ifA.wr_addr) == a) return ifA.wr_data;
    return mReg[a];
  endfunction

  function automatic logic expBusy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ifA.wr_en && int'(ifA.wr_addr) == a && !(ifA.rsv_en && int'(ifA.rsv_addr) == a))
      return 1'b0;
    return mBusy[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mReg[i]  = '0;
        mBusy[i] = 1'b0;
      end
      mErr = 1'b0;
      mTap = '0;
    end else begin
      if (ifA.wr_en && ifA.wr_addr != 0) begin
        if (!mBusy[ifA.wr_addr]) mErr = 1'b1;
        mReg[ifA.wr_addr]  = ifA.wr_data;
        mBusy[ifA.wr_addr] = 1'b0;
      end
      if (ifA.rsv_en && ifA.rsv_addr != 0) mBusy[ifA.rsv_addr] = 1'b1;
      mTap = mReg[TAP_IDX];
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int p = 0; p < NR; p++) begin
        chk($sformatf("cmpA.rd_data[%0d]", p), ifA.rd_data[p*DW +: DW], expData(int'(rdA(p)), 1'b1));
        chk($sformatf("cmpB.rd_data[%0d]", p), ifB.rd_data[p*DW +: DW], expData(int'(rdA(p)), 1'b0));
        chk($sformatf("cmpA.rd_busy[%0d]", p), DW'(ifA.rd_busy[p]), DW'(expBusy(int'(rdA(p)), 1'b1)));
        chk($sformatf("cmpB.rd_busy[%0d]", p), DW'(ifB.rd_busy[p]), DW'(expBusy(int'(rdA(p)), 1'b0)));
      end
      chk("cmpA.tap_out", ifA.tap_out, mTap);
      chk("cmpB.tap_out", ifB.tap_out, mTap);
      chk("cmpA.wr_err", DW'(ifA.wr_err), DW'(mErr));
      chk("cmpB.wr_err", DW'(ifB.wr_err), DW'(mErr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifA.wr_en  = 1'b0;
    ifA.rsv_en = 1'b0;
  endtask

  task automatic setRd(input int a0, input int a1, input int a2);
    ifA.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic doWrite(input int a, input logic [DW-1:0] d);
    ifA.wr_en   = 1'b1;
    ifA.wr_addr = AW'(a);
    ifA.wr_data = d;
  endtask

  task automatic doRsv(input int a);
    ifA.rsv_en   = 1'b1;
    ifA.rsv_addr = AW'(a);
  endtask

  task automatic pulseReset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    ifA.wr_addr  = '0;
    ifA.wr_data  = '0;
    ifA.rsv_addr = '0;
    setRd(0, 0, 0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkEn = 1'b1;

    // Reset clears stored data, tap, error and busy.
    doWrite(5, 32'hDEADBEEF);
    doRsv(6);
    step();
    idle();
    setRd(5, 6, 0);
    #2 chk("lit.r5_before_rst", ifA.rd_data[0 +: DW], 32'hDEADBEEF);
    pulseReset();
    #2;
    chk("lit.r5_after_rst", ifA.rd_data[0 +: DW], 32'h0);
    chk("lit.tap_after_rst", ifA.tap_out, 32'h0);
    chk("lit.err_after_rst", DW'(ifA.wr_err), 32'h0);
    chk("lit.busy_after_rst", DW'(ifA.rd_busy), 32'h0);

    // Same-cycle write forwarding versus the non-bypass build.
    step();
    doWrite(7, 32'h12345678);
    setRd(7, 0, 0);
    #2;
    chk("lit.bypassA", ifA.rd_data[0 +: DW], 32'h12345678);
    chk("lit.nobypassB", ifB.rd_data[0 +: DW], 32'h0);
    step();
    idle();
    #2 chk("lit.B_after_edge", ifB.rd_data[0 +: DW], 32'h12345678);

    // Register zero ignores writes and reservations.
    pulseReset();
    doWrite(0, 32'hFFFFFFFF);
    doRsv(0);
    setRd(0, 0, 0);
    #2 chk("lit.r0_data_bypass", ifA.rd_data[0 +: DW], 32'h0);
    step();
    idle();
    #2;
    chk("lit.r0_data", ifA.rd_data[0 +: DW], 32'h0);
    chk("lit.r0_busy", DW'(ifA.rd_busy[0]), 32'h0);
    chk("lit.r0_err", DW'(ifA.wr_err), 32'h0);

    // Reservation, retirement and same-cycle reserve+write on r3.
    doRsv(3);
    setRd(3, 0, 0);
    step();
    idle();
    #2 chk("lit.r3_busy", DW'(ifA.rd_busy[0]), 32'h1);
    doWrite(3, 32'h55);
    #2;
    chk("lit.r3_busy_masked", DW'(ifA.rd_busy[0]), 32'h0);
    chk("lit.r3_busy_nomaskB", DW'(ifB.rd_busy[0]), 32'h1);
    step();
    idle();
    #2;
    chk("lit.r3_busy_after", DW'(ifA.rd_busy[0]), 32'h0);
    chk("lit.r3_data", ifA.rd_data[0 +: DW], 32'h55);
    doRsv(3);
    step();
    doRsv(3);
    doWrite(3, 32'h66);
    #2 chk("lit.r3_rsvwr_busy_now", DW'(ifA.rd_busy[0]), 32'h1);
    step();
    idle();
    #2;
    chk("lit.r3_rsvwr_busy", DW'(ifA.rd_busy[0]), 32'h1);
    chk("lit.r3_rsvwr_data", ifA.rd_data[0 +: DW], 32'h66);
    chk("lit.r3_no_err", DW'(ifA.wr_err), 32'h0);

    // Unreserved write raises the sticky error but still lands.
    doWrite(9, 32'h99);
    setRd(9, 0, 0);
    step();
    idle();
    #2;
    chk("lit.err_set", DW'(ifA.wr_err), 32'h1);
    chk("lit.r9_data", ifA.rd_data[0 +: DW], 32'h99);
    repeat (3) step();
    #2 chk("lit.err_sticky", DW'(ifA.wr_err), 32'h1);

    // Tap latency and independent ports.
    doWrite(31, 32'h31313131);
    step();
    doWrite(12, 32'hA5A5A5A5);
    setRd(12, 0, 31);
    #2 chk("lit.tap_before", ifA.tap_out, 32'h0);
    step();
    idle();
    #2;
    chk("lit.tap_after", ifA.tap_out, 32'hA5A5A5A5);
    chk("lit.tapB_after", ifB.tap_out, 32'hA5A5A5A5);
    chk("lit.port0_r12", ifA.rd_data[0 +: DW], 32'hA5A5A5A5);
    chk("lit.port1_r0", ifA.rd_data[DW +: DW], 32'h0);
    chk("lit.port2_r31", ifA.rd_data[2*DW +: DW], 32'h31313131);

    // Random traffic on a narrow address range so hits and collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulseReset();
      end
      ifA.wr_en    = ($urandom_range(0, 2) != 0);
      ifA.wr_addr  = ($urandom_range(0, 3) == 0) ? AW'(TAP_IDX) : AW'($urandom_range(0, 7));
      ifA.wr_data  = $urandom;
      ifA.rsv_en   = ($urandom_range(0, 1) != 0);
      ifA.rsv_addr = AW'($urandom_range(0, 7));
      setRd($urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? int'(ifA.wr_addr) : $urandom_range(0, 31),
            ($urandom_range(0, 1) != 0) ? int'(ifA.rsv_addr) : TAP_IDX);
      step();
    end
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
